mole_game_ctrl: RTL and testbench

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

---
 rtl/mole_game_ctrl.sv | 140 ++++++++++++++
 tb/tb_mole_game_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mole_game_ctrl.sv
// rtl/mole_game_ctrl.sv - whack-a-mole game sequencer with tick prescaler and LFSR hole select
module mole_game_ctrl #(
    parameter int TICK_DIV   = 26_000_000,
    parameter int MOLE_TICKS = 2,
    parameter int ROUNDS     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    output logic [3:0] mole,
    output logic [1:0] countdown,
    output logic [7:0] score,
    output logic [3:0] round,
    output logic       playing,
    output logic       game_over
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_SPAWN = 3'd2;
    localparam logic [2:0] S_UP    = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [WW-1:0] wnd_q, wnd_d;
    logic [7:0]    lfsr_q;
    logic [3:0]    mole_q, mole_d;
    logic [1:0]    cd_q, cd_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    round_q, round_d;
    logic          playing_q, game_over_q;
    logic          tick;
    logic          lfsr_fb;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // Next-state and datapath decisions; a button in UP wins over a coincident timeout tick
    always_comb begin
        state_d = state_q;
        wnd_d   = wnd_q;
        mole_d  = mole_q;
        cd_d    = cd_q;
        score_d = score_q;
        round_d = round_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                mole_d = 4'b0000;
                if (start) begin
                    state_d = S_COUNT;
                    score_d = 8'd0;
                    round_d = 4'd0;
                    cd_d    = 2'd0;
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (cd_q == 2'd2) begin
                        state_d = S_SPAWN;
                    end else begin
                        cd_d = cd_q + 2'd1;
                    end
                end
            end
            S_SPAWN: begin
                mole_d  = 4'b0001 << lfsr_q[1:0];
                round_d = round_q + 4'd1;
                wnd_d   = '0;
                state_d = S_UP;
            end
            S_UP: begin
                if (btn != 4'b0000) begin
                    // any bit outside the lit hole makes the press a wrong one
                    if ((btn & ~mole_q) == 4'b0000 && score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    mole_d  = 4'b0000;
                    state_d = S_GAP;
                end else if (tick) begin
                    wnd_d = wnd_q + 1'b1;
                    if (wnd_q + 1'b1 == WW'(MOLE_TICKS)) begin
                        mole_d  = 4'b0000;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                mole_d = 4'b0000;
                if (tick) begin
                    state_d = (round_q == 4'(ROUNDS)) ? S_OVER : S_SPAWN;
                end
            end
            default: begin
                mole_d  = 4'b0000;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; prescaler restarts on every state change so each phase gets a full tick
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            wnd_q       <= '0;
            lfsr_q      <= 8'hA5;
            mole_q      <= 4'b0000;
            cd_q        <= 2'd0;
            score_q     <= 8'd0;
            round_q     <= 4'd0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= (state_d != state_q || tick) ? '0 : presc_q + 1'b1;
            wnd_q       <= wnd_d;
            lfsr_q      <= {lfsr_q[6:0], lfsr_fb};
            mole_q      <= mole_d;
            cd_q        <= cd_d;
            score_q     <= score_d;
            round_q     <= round_d;
            playing_q   <= (state_d == S_SPAWN) || (state_d == S_UP) || (state_d == S_GAP);
            game_over_q <= (state_d == S_OVER);
        end
    end

    assign mole      = mole_q;
    assign countdown = cd_q;
    assign score     = score_q;
    assign round     = round_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb/tb_mole_game_ctrl.sv - table-driven directed bench for mole_game_ctrl
module tb_mole_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] btn;
    logic [3:0] mole;
    logic [1:0] countdown;
    logic [7:0] score;
    logic [3:0] round;
    logic       playing;
    logic       game_over;

    mole_game_ctrl #(.TICK_DIV(4), .MOLE_TICKS(2), .ROUNDS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .mole      (mole),
        .countdown (countdown),
        .score     (score),
        .round     (round),
        .playing   (playing),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed A5
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // bm: 0 drive b, 1 drive expected mole, 2 drive complement of expected mole
    // latch: DUT is in SPAWN after this record, capture expected mole
    typedef struct {
        int         n;
        bit         rst;
        bit         st;
        bit [1:0]   bm;
        logic [3:0] b;
        bit         latch;
        bit         mexp;
        bit [1:0]   cd;
        bit [7:0]   sc;
        bit [3:0]   rd;
        bit         pl;
        bit         go;
        bit         lf;
    } vec_t;

    vec_t       tbl[$];
    int         pass_cnt = 0;
    int         total = 0;
    logic [3:0] exp_mole = 4'b0000;

    task automatic v(input int n, input bit rst, input bit st, input bit [1:0] bm, input logic [3:0] b,
                     input bit latch, input bit mexp, input bit [1:0] cd, input bit [7:0] sc,
                     input bit [3:0] rd, input bit pl, input bit go, input bit lf);
        vec_t r;
        r = '{n, rst, st, bm, b, latch, mexp, cd, sc, rd, pl, go, lf};
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'b0000;

        // n  rst st bm b     lat mex cd sc rd pl go lf
        // reset overrides start and btn
        v(2,  1, 1, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1);
        v(3,  0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
        // game 1: hit, wrong, miss
        v(1,  0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(3,  0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0);
        v(4,  0, 0, 0, 4'h0, 0, 0, 2, 0, 0, 0, 0, 0);
        v(3,  0, 0, 0, 4'h0, 0, 0, 2, 0, 0, 0, 0, 0);
        v(1,  0, 0, 0, 4'h0, 1, 0, 2, 0, 0, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 0, 1, 1, 0, 0);
        v(1,  0, 0, 1, 4'h0, 0, 0, 2, 1, 1, 1, 0, 0);
        v(3,  0, 1, 0, 4'h0, 0, 0, 2, 1, 1, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 1, 0, 2, 1, 1, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 1, 2, 1, 0, 0);
        v(1,  0, 0, 2, 4'h0, 0, 0, 2, 1, 2, 1, 0, 0);
        v(4,  0, 0, 0, 4'h0, 1, 0, 2, 1, 2, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 1, 3, 1, 0, 0);
        v(7,  0, 0, 0, 4'h0, 0, 1, 2, 1, 3, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 0, 2, 1, 3, 1, 0, 0);
        v(3,  0, 0, 0, 4'h0, 0, 0, 2, 1, 3, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 0, 2, 1, 3, 0, 1, 0);
        v(3,  0, 0, 0, 4'hF, 0, 0, 2, 1, 3, 0, 1, 0);
        v(1,  0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        // game 2: three hits, middle one on the timeout tick, held button in gap
        v(11, 0, 0, 0, 4'h0, 0, 0, 2, 0, 0, 0, 0, 0);
        v(1,  0, 0, 0, 4'h0, 1, 0, 2, 0, 0, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 0, 1, 1, 0, 0);
        v(1,  0, 0, 1, 4'h0, 0, 0, 2, 1, 1, 1, 0, 0);
        v(4,  0, 0, 1, 4'h0, 1, 0, 2, 1, 1, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 1, 2, 1, 0, 0);
        v(7,  0, 0, 0, 4'h0, 0, 1, 2, 1, 2, 1, 0, 0);
        v(1,  0, 0, 1, 4'h0, 0, 0, 2, 2, 2, 1, 0, 0);
        v(4,  0, 0, 0, 4'h0, 1, 0, 2, 2, 2, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 2, 3, 1, 0, 0);
        v(1,  0, 0, 1, 4'h0, 0, 0, 2, 3, 3, 1, 0, 0);
        v(4,  0, 0, 0, 4'h0, 0, 0, 2, 3, 3, 0, 1, 0);
        v(1,  0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        // game 3: reset mid-UP with score 2
        v(12, 0, 0, 0, 4'h0, 1, 0, 2, 0, 0, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 0, 1, 1, 0, 0);
        v(1,  0, 0, 1, 4'h0, 0, 0, 2, 1, 1, 1, 0, 0);
        v(4,  0, 0, 0, 4'h0, 1, 0, 2, 1, 1, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 1, 2, 1, 0, 0);
        v(1,  0, 0, 1, 4'h0, 0, 0, 2, 2, 2, 1, 0, 0);
        v(4,  0, 0, 0, 4'h0, 1, 0, 2, 2, 2, 1, 0, 0);
        v(1,  0, 0, 0, 4'h0, 0, 1, 2, 2, 3, 1, 0, 0);
        v(1,  1, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1);
        v(3,  0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                reset = tbl[i].rst;
                start = tbl[i].st;
                case (tbl[i].bm)
                    2'd1:    btn = exp_mole;
                    2'd2:    btn = ~exp_mole;
                    default: btn = tbl[i].b;
                endcase
                step();
            end
            if (tbl[i].latch) exp_mole = 4'b0001 << m_lfsr[1:0];
            chk($sformatf("v%0d_mole", i), mole, tbl[i].mexp ? exp_mole : 4'b0000);
            chk($sformatf("v%0d_countdown", i), countdown, tbl[i].cd);
            chk($sformatf("v%0d_score", i), score, tbl[i].sc);
            chk($sformatf("v%0d_round", i), round, tbl[i].rd);
            chk($sformatf("v%0d_playing", i), playing, tbl[i].pl);
            chk($sformatf("v%0d_game_over", i), game_over, tbl[i].go);
            if (tbl[i].lf) chk($sformatf("v%0d_lfsr", i), dut.lfsr_q, 8'hA5);
        end

        // Start-to-spawn latency measured with a bounded wait
        reset = 1'b0;
        btn   = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 1;
        while (!playing && cycles < 40) begin
            step();
            cycles++;
        end
        chk("spawn_latency", cycles, 13);
        chk("spawn_round", round, 0);
        exp_mole = 4'b0001 << m_lfsr[1:0];
        step();
        chk("up_mole", mole, exp_mole);
        chk("up_round", round, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
